// File: rtl/alu_uart_intf.sv
// Byte-serial ALU core sitting between a UART receiver and transmitter.
// Collects A, B, opcode; returns one result byte with a start strobe.
module alu_uart_intf #(
  parameter int SIZEDATA   = 8,
  parameter int SIZEOP     = 6,
  parameter int CLK_FREQ   = 5000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  output logic                o_tick,
  output logic [SIZEDATA-1:0] o_alu_datoa,
  output logic [SIZEDATA-1:0] o_alu_datob,
  output logic [SIZEDATA-1:0] o_alu_opcode,
  output logic [SIZEDATA-1:0] o_tx_result,
  output logic                o_tx_signal
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [SIZEOP-1:0] OP_ADD = SIZEOP'(8'h20);
  localparam logic [SIZEOP-1:0] OP_SUB = SIZEOP'(8'h22);
  localparam logic [SIZEOP-1:0] OP_AND = SIZEOP'(8'h24);
  localparam logic [SIZEOP-1:0] OP_OR  = SIZEOP'(8'h25);
  localparam logic [SIZEOP-1:0] OP_XOR = SIZEOP'(8'h26);
  localparam logic [SIZEOP-1:0] OP_NOR = SIZEOP'(8'h27);
  localparam logic [SIZEOP-1:0] OP_SRA = SIZEOP'(8'h03);
  localparam logic [SIZEOP-1:0] OP_SRL = SIZEOP'(8'h02);

  typedef enum logic [1:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic                rx_prev;
  logic                accept;
  logic [SIZEOP-1:0]   op;
  logic [SIZEDATA-1:0] alu_res;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end

  // A level-held rx_done must count as a single byte.
  assign accept = i_rx_done & ~rx_prev;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) rx_prev <= 1'b0;
    else          rx_prev <= i_rx_done;
  end

  assign op = o_alu_opcode[SIZEOP-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = o_alu_datoa + o_alu_datob;
      OP_SUB:  alu_res = o_alu_datoa - o_alu_datob;
      OP_AND:  alu_res = o_alu_datoa & o_alu_datob;
      OP_OR:   alu_res = o_alu_datoa | o_alu_datob;
      OP_XOR:  alu_res = o_alu_datoa ^ o_alu_datob;
      OP_NOR:  alu_res = ~(o_alu_datoa | o_alu_datob);
      OP_SRA:  alu_res = SIZEDATA'($signed(o_alu_datoa) >>> o_alu_datob);
      OP_SRL:  alu_res = o_alu_datoa >> o_alu_datob;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (accept) state_nxt = GET_B;
      GET_B:   if (accept) state_nxt = GET_OP;
      GET_OP:  if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state        <= GET_A;
      o_alu_datoa  <= '0;
      o_alu_datob  <= '0;
      o_alu_opcode <= '0;
      o_tx_result  <= '0;
      o_tx_signal  <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_tx_signal <= (state == EXEC);
      if (state == GET_A && accept)
        o_alu_datoa <= i_rx_data;
      if (state == GET_B && accept)
        o_alu_datob <= i_rx_data;
      if (state == GET_OP && accept)
        o_alu_opcode <= {{(SIZEDATA-SIZEOP){1'b0}},
                         i_rx_data[SIZEOP-1:0]};
      if (state == EXEC)
        o_tx_result <= alu_res;
    end
  end

endmodule

// File: tb/tb_alu_uart_intf.sv
// Directed bench for alu_uart_intf: baud tick, byte collection,
// opcode sweep, reset recovery and held rx_done handling.
module tb_alu_uart_intf;

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tick;
  logic [7:0] datoa;
  logic [7:0] datob;
  logic [7:0] opcode;
  logic [7:0] result;
  logic       tx_sig;

  int n_vec;
  int n_err;

  alu_uart_intf dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .o_tick       (tick),
    .o_alu_datoa  (datoa),
    .o_alu_datob  (datob),
    .o_alu_opcode (opcode),
    .o_tx_result  (result),
    .o_tx_signal  (tx_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] o, input logic [7:0] exp);
    int pulses;
    int at;
    pulses = 0;
    at = 0;
    send_byte(a, 3);
    send_byte(b, 3);
    @(negedge clk);
    rx_data = o;
    rx_done = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (tx_sig) begin
        pulses++;
        at = i;
      end
      if (i == 3) rx_done = 1'b0;
    end
    chk($sformatf("datoa_%02h", o), datoa, a);
    chk($sformatf("datob_%02h", o), datob, b);
    chk($sformatf("opcode_%02h", o), opcode, o & 8'h3f);
    chk($sformatf("result_%02h", o), result, exp);
    chk($sformatf("strobe_cnt_%02h", o), pulses, 1);
    chk($sformatf("strobe_pos_%02h", o), at, 2);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk($sformatf("tick_c%0d", k), tick, (k % 32) == 0);
    end
    chk("idle_datoa", datoa, 0);
    chk("idle_datob", datob, 0);
    chk("idle_opcode", opcode, 0);
    chk("idle_result", result, 0);
    chk("idle_txsig", tx_sig, 0);

    run_op(8'h02, 8'h04, 8'h20, 8'h06);
    run_op(8'hf0, 8'h02, 8'h22, 8'hee);
    run_op(8'hf0, 8'h02, 8'h03, 8'hfc);
    run_op(8'hf0, 8'h02, 8'h02, 8'h3c);
    run_op(8'hf0, 8'h0f, 8'h24, 8'h00);
    run_op(8'hf0, 8'h0f, 8'h25, 8'hff);
    run_op(8'hf0, 8'h0f, 8'h26, 8'hff);
    run_op(8'hf0, 8'h0f, 8'h27, 8'h00);
    run_op(8'h7f, 8'h01, 8'h20, 8'h80);
    run_op(8'hf0, 8'h09, 8'h03, 8'hff);
    run_op(8'hf0, 8'h08, 8'h02, 8'h00);
    run_op(8'h05, 8'h03, 8'h3f, 8'h00);

    send_byte(8'h09, 3);
    send_byte(8'h07, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_datoa", datoa, 0);
    chk("midrst_datob", datob, 0);
    chk("midrst_result", result, 0);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 8'h20, 8'h02);

    send_byte(8'h11, 50);
    chk("hold_datoa", datoa, 8'h11);
    chk("hold_datob", datob, 8'h01);
    send_byte(8'h22, 3);
    chk("hold_next_datoa", datoa, 8'h11);
    chk("hold_next_datob", datob, 8'h22);
    send_byte(8'h20, 3);
    repeat (2) @(negedge clk);
    chk("hold_result", result, 8'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_uart_intf.md
Name: alu_uart_intf

Overview:
- Arithmetic core between a UART receiver and a UART transmitter.
- Collects three received bytes in order (operand A, operand B, opcode) and evaluates them with an internal combinational ALU.
- Hands the 8-bit result to the transmitter with a one-cycle start strobe.
- Also contains the baud-rate tick generator (16x oversampling) that drives the UART RX/TX blocks.

Parameters:
- SIZEDATA, 8, data/operand/result width in bits.
- SIZEOP, 6, ALU opcode width in bits.
- CLK_FREQ, 5000000, system clock frequency in Hz.
- BAUD_RATE, 9600, UART baud rate.
- OVERSAMPLE, 16, ticks per UART bit; tick divisor = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncated (32 at defaults).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_done  in  1  UART RX byte-complete flag (level; may stay high several cycles).
- i_rx_data  in  SIZEDATA  received byte, valid while i_rx_done high.
- o_tick  out  1  baud oversampling tick, one-cycle pulse.
- o_alu_datoa  out  SIZEDATA  registered operand A.
- o_alu_datob  out  SIZEDATA  registered operand B.
- o_alu_opcode  out  SIZEDATA  registered opcode byte; upper bits zero.
- o_tx_result  out  SIZEDATA  result byte for UART TX, held until next result.
- o_tx_signal  out  1  TX start strobe, one-cycle pulse.

Behaviour:
- Reset (i_reset=0, async): all outputs 0, FSM in GET_A, tick counter 0, rx_done edge register 0.
- Baud generator:
  - Free-running counter 0..DIVISOR-1.
  - o_tick=1 for exactly one cycle when the counter wraps, i.e. every DIVISOR cycles.
  - First tick occurs DIVISOR cycles after reset release.
- Byte acceptance: only on the rising edge of i_rx_done (i_rx_done=1 and previous-cycle value 0). A held-high i_rx_done counts as one byte.
- FSM states: GET_A -> GET_B -> GET_OP -> EXEC -> GET_A.
  - GET_A, on accept: o_alu_datoa <= i_rx_data; go to GET_B.
  - GET_B, on accept: o_alu_datob <= i_rx_data; go to GET_OP.
  - GET_OP, on accept: o_alu_opcode <= {zeros, i_rx_data[SIZEOP-1:0]}; go to EXEC.
  - EXEC (one cycle, bytes ignored): o_tx_result <= ALU result; o_tx_signal <= 1; go to GET_A.
  - o_tx_signal returns to 0 on the following cycle.
- Latency: strobe is high in the 2nd cycle after the clock edge that samples the opcode's rx_done rising edge.
- A byte arriving during EXEC is dropped.
- Reset mid-sequence discards partial operands and returns to GET_A.
- ALU (combinational, operands treated as signed two's complement, result truncated to SIZEDATA):
  - 0x20 ADD A+B
  - 0x22 SUB A-B
  - 0x24 AND
  - 0x25 OR
  - 0x26 XOR
  - 0x27 NOR
  - 0x03 SRA: A >>> B, sign fill; shift amount >= SIZEDATA gives all sign bits.
  - 0x02 SRL: A >> B, zero fill; shift amount >= SIZEDATA gives 0.
  - Any other opcode gives result 0; it is still transmitted with a strobe.
- Overflow wraps modulo 2^SIZEDATA; no flags.

Test Plan:
- Reset then idle 100 cycles -> all outputs 0; o_tick pulses every 32 cycles, exactly one cycle wide.
- Bytes 0x02, 0x04, 0x20 (each rx_done held 3 cycles) -> o_alu_datoa=0x02, o_alu_datob=0x04, o_alu_opcode=0x20. o_tx_result=0x06 with a single o_tx_signal pulse, 2 cycles after the opcode edge.
- Opcode sweep:
  - A=0xF0, B=0x02: SUB -> 0xEE; SRA -> 0xFC; SRL -> 0x3C.
  - A=0xF0, B=0x0F: AND -> 0x00; OR -> 0xFF; XOR -> 0xFF; NOR -> 0x00.
  - A=0x7F, B=0x01: ADD -> 0x80 (wrap).
- Unknown opcode 0x3F with A=5, B=3 -> o_tx_result=0x00, o_tx_signal pulses.
- Send A and B, assert reset, then send 0x01, 0x01, 0x20 -> result 0x02 (stale operands discarded).
- i_rx_done held high for 50 cycles -> only one byte consumed; FSM advances one state.
